// File: rtl/capture_pkg.sv
// Shared types and defaults for the trigger-driven capture buffer controller.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2,
    READ  = 2'd3
  } cap_state_e;

  localparam int unsigned DEF_DEPTH      = 16;
  localparam int unsigned DEF_RD_LATENCY = 1;

endpackage

// File: rtl/capture_addr_cnt.sv
// Address counter running 0..DEPTH-1 with synchronous clear, enable and last flag.
module capture_addr_cnt
  import capture_pkg::*;
#(
  parameter  int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_cnt,
  output logic              o_last
);

  assign o_last = (o_cnt == ADDR_W'(DEPTH - 1));

  // Returns to 0 after DEPTH-1 so non-power-of-2 depths never leave the buffer range
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= o_last ? '0 : o_cnt + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/capture_ram_ctrl.sv
// Trigger-driven capture controller: fills DEPTH BRAM entries, then streams them out.
// Optional level re-arm after readout: define CAPTURE_AUTO_REARM_EN.
module capture_ram_ctrl
  import capture_pkg::*;
#(
  parameter  int unsigned DEPTH      = DEF_DEPTH,
  parameter  int unsigned RD_LATENCY = DEF_RD_LATENCY,
  localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_trigger,
  input  logic              i_abort,
  input  logic              i_rd_start,
  input  logic              i_rd_ready,
  output logic              o_wr_ena,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_rd_ena,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_valid,
  output logic              o_full,
  output logic              o_busy,
  output logic              o_rd_done
);

  cap_state_e            state_q, state_d;
  logic                  trig_d, trig_vld, trig_edge;
  logic                  wr_clr, wr_en, wr_last;
  logic                  rd_clr, rd_en, rd_last;
  logic                  rd_fin;
  logic [RD_LATENCY-1:0] vld_sr;

  // trig_vld masks the first cycle after reset so a level held through reset is not an edge
  assign trig_edge = i_trigger & ~trig_d & trig_vld;

  assign wr_en  = (state_q == WRITE);
  assign wr_clr = i_abort | (state_q != WRITE);
  assign rd_en  = (state_q == READ) & o_rd_ena;
  assign rd_clr = i_abort | (state_q != READ);

  capture_addr_cnt #(.DEPTH(DEPTH)) u_wr_cnt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (wr_clr),
    .i_en    (wr_en),
    .o_cnt   (o_wr_addr),
    .o_last  (wr_last)
  );

  capture_addr_cnt #(.DEPTH(DEPTH)) u_rd_cnt (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (rd_clr),
    .i_en    (rd_en),
    .o_cnt   (o_rd_addr),
    .o_last  (rd_last)
  );

  always_comb begin
    state_d = state_q;
    rd_fin  = 1'b0;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:  if (trig_edge)  state_d = WRITE;
        WRITE: if (wr_last)    state_d = FULL;
        FULL:  if (i_rd_start) state_d = READ;
        READ: begin
          if (o_rd_ena && rd_last) begin
            state_d = IDLE;
            rd_fin  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      trig_d   <= 1'b0;
      trig_vld <= 1'b0;
    end else begin
      state_q  <= state_d;
      trig_vld <= 1'b1;
`ifdef CAPTURE_AUTO_REARM_EN
      trig_d   <= rd_fin ? 1'b0 : i_trigger;
`else
      trig_d   <= i_trigger;
`endif
    end
  end

  // Outputs are registered from the next-state decode so they align with the state register
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_ena  <= 1'b0;
      o_rd_ena  <= 1'b0;
      o_full    <= 1'b0;
      o_busy    <= 1'b0;
      o_rd_done <= 1'b0;
      vld_sr    <= '0;
    end else begin
      o_wr_ena  <= (state_d == WRITE);
      o_rd_ena  <= (state_d == READ) & i_rd_ready;
      o_full    <= (state_d == FULL) | (state_d == READ);
      o_busy    <= (state_d == WRITE) | (state_d == READ);
      o_rd_done <= rd_fin;
      vld_sr[0] <= o_rd_ena;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  assign o_rd_valid = vld_sr[RD_LATENCY-1];

endmodule

// File: tb/tb_capture_ram_ctrl.sv
// Scoreboard bench for capture_ram_ctrl with DEPTH=8, RD_LATENCY=2.
module tb_capture_ram_ctrl;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned RD_LATENCY = 2;
  localparam int unsigned ADDR_W     = $clog2(DEPTH);
`ifdef CAPTURE_AUTO_REARM_EN
  localparam int unsigned HOLD_WRITES = 2 * DEPTH;
`else
  localparam int unsigned HOLD_WRITES = DEPTH;
`endif

  logic              clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_trigger = 1'b0;
  logic              i_abort = 1'b0;
  logic              i_rd_start = 1'b0;
  logic              i_rd_ready = 1'b0;
  logic              o_wr_ena, o_rd_ena, o_rd_valid, o_full, o_busy, o_rd_done;
  logic [ADDR_W-1:0] o_wr_addr, o_rd_addr;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned wr_q[$];
  int unsigned rd_q[$];

  always #5 clk = ~clk;

  capture_ram_ctrl #(.DEPTH(DEPTH), .RD_LATENCY(RD_LATENCY)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_trigger  (i_trigger),
    .i_abort    (i_abort),
    .i_rd_start (i_rd_start),
    .i_rd_ready (i_rd_ready),
    .o_wr_ena   (o_wr_ena),
    .o_wr_addr  (o_wr_addr),
    .o_rd_ena   (o_rd_ena),
    .o_rd_addr  (o_rd_addr),
    .o_rd_valid (o_rd_valid),
    .o_full     (o_full),
    .o_busy     (o_busy),
    .o_rd_done  (o_rd_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n   = 1'b0;
    i_trigger = 1'b1;
    #12;
    n_vec++;
    if ({o_wr_ena, o_rd_ena, o_rd_valid, o_full, o_busy, o_rd_done} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000000",
               {o_wr_ena, o_rd_ena, o_rd_valid, o_full, o_busy, o_rd_done});
    end
    n_vec++;
    if (o_wr_addr !== '0 || o_rd_addr !== '0) begin
      n_err++;
      $display("FAIL reset_addr: got wr=%0d rd=%0d want 0/0", o_wr_addr, o_rd_addr);
    end
    i_rst_n = 1'b1;
    repeat (4) tick();
    n_vec++;
    if (o_wr_ena !== 1'b0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL held_trigger_no_edge: got wr_ena=%b busy=%b want 0/0", o_wr_ena, o_busy);
    end
    i_trigger = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_capture(input bit retrig);
    int unsigned wcount = 0;
    int unsigned exp_a;
    for (int unsigned a = 0; a < DEPTH; a++) wr_q.push_back(a);
    i_trigger = 1'b1;
    tick();
    i_trigger = 1'b0;
    n_vec++;
    if (o_wr_ena !== 1'b1) begin
      n_err++;
      $display("FAIL cap_first_write: got wr_ena=%b want 1", o_wr_ena);
    end
    for (int unsigned k = 0; k < 16; k++) begin
      if (o_wr_ena === 1'b1) begin
        wcount++;
        n_vec++;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL cap_extra_write: got write at addr %0d want none", o_wr_addr);
        end else begin
          exp_a = wr_q.pop_front();
          if (o_wr_addr !== ADDR_W'(exp_a)) begin
            n_err++;
            $display("FAIL cap_wr_addr: got %0d want %0d", o_wr_addr, exp_a);
          end
        end
      end
      if (k < DEPTH) begin
        n_vec++;
        if (o_full !== 1'b0 || o_busy !== 1'b1) begin
          n_err++;
          $display("FAIL cap_busy_flags k=%0d: got full=%b busy=%b want 0/1", k, o_full, o_busy);
        end
      end else if (k == DEPTH) begin
        n_vec++;
        if (o_full !== 1'b1 || o_busy !== 1'b0) begin
          n_err++;
          $display("FAIL cap_full_flags: got full=%b busy=%b want 1/0", o_full, o_busy);
        end
      end
      // Re-trigger while writing addr 3, and again once FULL
      i_trigger = retrig && (k == 3 || k == 10);
      tick();
    end
    i_trigger = 1'b0;
    n_vec++;
    if (wcount != DEPTH || wr_q.size() != 0) begin
      n_err++;
      $display("FAIL cap_write_count: got %0d want %0d", wcount, DEPTH);
      wr_q.delete();
    end
  endtask

  task automatic test_readout(input bit toggle);
    int unsigned issued = 0;
    int unsigned nvalid = 0;
    int unsigned ndone  = 0;
    int unsigned exp_a;
    logic [3:0]  hist = '0;
    logic        pred;
    logic        done_exp = 1'b0;
    for (int unsigned a = 0; a < DEPTH; a++) rd_q.push_back(a);
    i_rd_ready = 1'b1;
    i_rd_start = 1'b1;
    tick();
    i_rd_start = 1'b0;
    pred = 1'b1;
    for (int unsigned k = 0; k < 40; k++) begin
      n_vec++;
      if (o_rd_ena !== pred) begin
        n_err++;
        $display("FAIL rd_ena k=%0d: got %b want %b", k, o_rd_ena, pred);
      end
      if (pred) begin
        issued++;
        exp_a = rd_q.pop_front();
        n_vec++;
        if (o_rd_addr !== ADDR_W'(exp_a)) begin
          n_err++;
          $display("FAIL rd_addr: got %0d want %0d", o_rd_addr, exp_a);
        end
      end
      n_vec++;
      if (o_rd_valid !== hist[RD_LATENCY-1]) begin
        n_err++;
        $display("FAIL rd_valid k=%0d: got %b want %b", k, o_rd_valid, hist[RD_LATENCY-1]);
      end
      if (o_rd_valid === 1'b1) nvalid++;
      n_vec++;
      if (o_rd_done !== done_exp) begin
        n_err++;
        $display("FAIL rd_done k=%0d: got %b want %b", k, o_rd_done, done_exp);
      end
      if (o_rd_done === 1'b1) ndone++;
      done_exp   = pred && (issued == DEPTH);
      hist       = {hist[2:0], pred};
      i_rd_ready = toggle ? ((k + 1) % 2 == 0) : 1'b1;
      pred       = (issued < DEPTH) && i_rd_ready;
      tick();
    end
    n_vec++;
    if (nvalid != DEPTH || ndone != 1) begin
      n_err++;
      $display("FAIL rd_counts: got valid=%0d done=%0d want %0d/1", nvalid, ndone, DEPTH);
    end
    n_vec++;
    if (o_full !== 1'b0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL rd_end_flags: got full=%b busy=%b want 0/0", o_full, o_busy);
    end
  endtask

  task automatic test_abort();
    int unsigned exp_a;
    for (int unsigned a = 0; a < 6; a++) wr_q.push_back(a);
    i_trigger = 1'b1;
    tick();
    i_trigger = 1'b0;
    for (int unsigned k = 0; k < 20; k++) begin
      if (o_wr_ena === 1'b1) begin
        n_vec++;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL abort_extra_write: got write at addr %0d want none", o_wr_addr);
        end else begin
          exp_a = wr_q.pop_front();
          if (o_wr_addr !== ADDR_W'(exp_a)) begin
            n_err++;
            $display("FAIL abort_wr_addr: got %0d want %0d", o_wr_addr, exp_a);
          end
        end
      end
      if (k == 6) begin
        n_vec++;
        if ({o_wr_ena, o_full, o_busy, o_rd_done} !== 4'b0 || o_wr_addr !== '0) begin
          n_err++;
          $display("FAIL abort_idle: got ena/full/busy/done=%b addr=%0d want 0000/0",
                   {o_wr_ena, o_full, o_busy, o_rd_done}, o_wr_addr);
        end
      end
      i_abort = (k == 5);
      tick();
    end
    n_vec++;
    if (wr_q.size() != 0) begin
      n_err++;
      $display("FAIL abort_writes_missing: got %0d pending want 0", wr_q.size());
      wr_q.delete();
    end
    i_abort   = 1'b1;
    i_trigger = 1'b1;
    tick();
    i_abort = 1'b0;
    repeat (3) begin
      n_vec++;
      if (o_wr_ena !== 1'b0 || o_busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort_beats_edge: got wr_ena=%b busy=%b want 0/0", o_wr_ena, o_busy);
      end
      tick();
    end
    i_trigger  = 1'b0;
    tick();
    i_rd_start = 1'b1;
    i_rd_ready = 1'b1;
    tick();
    i_rd_start = 1'b0;
    n_vec++;
    if (o_rd_ena !== 1'b0 || o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL rd_start_in_idle: got rd_ena=%b busy=%b want 0/0", o_rd_ena, o_busy);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    i_rd_ready = 1'b1;
    i_rd_start = 1'b1;
    tick();
    i_rd_start = 1'b0;
    repeat (2) tick();
    n_vec++;
    if (o_rd_ena !== 1'b1 || o_rd_addr !== ADDR_W'(2)) begin
      n_err++;
      $display("FAIL mid_read_setup: got rd_ena=%b addr=%0d want 1/2", o_rd_ena, o_rd_addr);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_wr_ena, o_rd_ena, o_rd_valid, o_full, o_busy, o_rd_done} !== 6'b0) begin
      n_err++;
      $display("FAIL async_reset_flags: got %b want 000000",
               {o_wr_ena, o_rd_ena, o_rd_valid, o_full, o_busy, o_rd_done});
    end
    n_vec++;
    if (o_wr_addr !== '0 || o_rd_addr !== '0) begin
      n_err++;
      $display("FAIL async_reset_addr: got wr=%0d rd=%0d want 0/0", o_wr_addr, o_rd_addr);
    end
    #3 i_rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_level_hold();
    int unsigned wcount = 0;
    bit          rd_started = 1'b0;
    i_rd_ready = 1'b1;
    i_trigger  = 1'b1;
    tick();
    for (int unsigned k = 0; k < 60; k++) begin
      if (k == 30) i_trigger = 1'b0;
      if (o_wr_ena === 1'b1) wcount++;
      i_rd_start = 1'b0;
      if (!rd_started && o_full === 1'b1 && o_busy === 1'b0) begin
        i_rd_start = 1'b1;
        rd_started = 1'b1;
      end
      tick();
    end
    i_rd_start = 1'b0;
    n_vec++;
    if (!rd_started) begin
      n_err++;
      $display("FAIL hold_no_full: got full never seen want full");
    end
    n_vec++;
    if (wcount != HOLD_WRITES) begin
      n_err++;
      $display("FAIL hold_write_count: got %0d want %0d", wcount, HOLD_WRITES);
    end
  endtask

  initial begin
    test_reset();
    test_capture(1'b0);
    test_readout(1'b0);
    test_capture(1'b1);
    test_readout(1'b1);
    test_abort();
    test_capture(1'b0);
    test_reset_mid_read();
    test_level_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
